div_sequencer: RTL

- Controller for the calculator's shared shift-subtract (restoring) divider datapath.
- Accepts a start pulse from the main calculator controller and checks for divide-by-zero.
- Sequences load, shift and trial-subtract steps for WIDTH iterations, then returns a one-cycle done pulse.
- Holds no data itself: it drives datapath enables and reacts to datapath status flags.

---
 rtl/div_sequencer_if.sv | 45 ++++
 rtl/div_sequencer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/div_sequencer_if.sv
// Handshake/status bundle between the calculator controller, the divider datapath and div_sequencer.
// Latency: none (wires only).
// Backpressure: none; start is a request pulse, done is a one-cycle pulse.
// Optional macro DIV_ZERO_SKIP_EN adds the dividend_zero flag.
interface div_sequencer_if #(
   parameter int CNT_W = 5
);
   // requests and datapath status flags into the sequencer
   logic             start;
   logic             divisor_zero;
   logic             rem_neg;
`ifdef DIV_ZERO_SKIP_EN
   logic             dividend_zero;
`endif
   // datapath enables and status out of the sequencer
   logic             load;
   logic             shift_en;
   logic             rem_we;
   logic             q_bit;
   logic             busy;
   logic             done;
   logic             div_by_zero;
   logic [CNT_W-1:0] iter;
   logic [2:0]       ps;

`ifdef DIV_ZERO_SKIP_EN
   modport master (
      output start, divisor_zero, rem_neg, dividend_zero,
      input  load, shift_en, rem_we, q_bit, busy, done, div_by_zero, iter, ps
   );
   modport slave (
      input  start, divisor_zero, rem_neg, dividend_zero,
      output load, shift_en, rem_we, q_bit, busy, done, div_by_zero, iter, ps
   );
`else
   modport master (
      output start, divisor_zero, rem_neg,
      input  load, shift_en, rem_we, q_bit, busy, done, div_by_zero, iter, ps
   );
   modport slave (
      input  start, divisor_zero, rem_neg,
      output load, shift_en, rem_we, q_bit, busy, done, div_by_zero, iter, ps
   );
`endif
endinterface

// File: rtl/div_sequencer.sv
// Control FSM for the shared restoring shift-subtract divider datapath.
// Latency: start edge k -> LOAD in k+1, done in k+2+2*WIDTH (ERR in k+2, zero-dividend skip in k+2).
// Backpressure: none; start is only sampled in IDLE and is dropped otherwise (no queuing).
// Optional macro DIV_ZERO_SKIP_EN: dividend_zero flag lets LOAD jump straight to DONE.
module div_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5   // 2**CNT_W must exceed WIDTH so iter can reach WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   div_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SHIFT = 3'd2,
      S_TRIAL = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   // raw 3-bit register so the unused codes 6/7 stay representable and recoverable
   logic [2:0]       r_ps;
   logic [2:0]       w_next;
   logic [CNT_W-1:0] r_iter;
   logic             w_dividend_zero;

   logic w_load;
   logic w_shift_en;
   logic w_rem_we;
   logic w_q_bit;
   logic w_busy;
   logic w_done;
   logic w_div_by_zero;

`ifdef DIV_ZERO_SKIP_EN
   assign w_dividend_zero = bus.dividend_zero;
`else
   assign w_dividend_zero = 1'b0;
`endif

   // state register, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ps <= S_IDLE;
      end else begin
         r_ps <= w_next;
      end
   end

   // iteration counter: cleared on LOAD, advanced once per trial-subtract
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_iter <= '0;
      end else if (r_ps == S_LOAD) begin
         r_iter <= '0;
      end else if (r_ps == S_TRIAL) begin
         r_iter <= r_iter + 1'b1;
      end
   end

   // next-state and output decode; rem_we/q_bit follow rem_neg combinationally in TRIAL
   always_comb begin
      w_next        = S_IDLE;
      w_load        = 1'b0;
      w_shift_en    = 1'b0;
      w_rem_we      = 1'b0;
      w_q_bit       = 1'b0;
      w_busy        = 1'b0;
      w_done        = 1'b0;
      w_div_by_zero = 1'b0;
      case (r_ps)
         S_IDLE: begin
            w_next = bus.start ? S_LOAD : S_IDLE;
         end
         S_LOAD: begin
            w_load = 1'b1;
            w_busy = 1'b1;
            // divisor check wins: a 0/0 request must still report the error
            if (bus.divisor_zero) begin
               w_next = S_ERR;
            end else if (w_dividend_zero) begin
               w_next = S_DONE;
            end else begin
               w_next = S_SHIFT;
            end
         end
         S_SHIFT: begin
            w_shift_en = 1'b1;
            w_busy     = 1'b1;
            w_next     = S_TRIAL;
         end
         S_TRIAL: begin
            w_busy   = 1'b1;
            w_q_bit  = ~bus.rem_neg;
            w_rem_we = ~bus.rem_neg;
            w_next   = (r_iter == LAST_ITER) ? S_DONE : S_SHIFT;
         end
         S_DONE: begin
            w_done = 1'b1;
            w_next = S_IDLE;
         end
         S_ERR: begin
            w_done        = 1'b1;
            w_div_by_zero = 1'b1;
            w_next        = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   assign bus.load        = w_load;
   assign bus.shift_en    = w_shift_en;
   assign bus.rem_we      = w_rem_we;
   assign bus.q_bit       = w_q_bit;
   assign bus.busy        = w_busy;
   assign bus.done        = w_done;
   assign bus.div_by_zero = w_div_by_zero;
   assign bus.iter        = r_iter;
   assign bus.ps          = r_ps;

endmodule
